// File: rtl/mem_access_ctrl_if.sv
// Request/response bundle between a load/store unit and the memory it drives.
// The slave modport is the controller's view; master is the requester/memory model.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              start;
    logic              rw;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              mem_en;
    logic              mem_rw;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_mfc;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  start, rw, size, sign_ext, addr, wdata, mem_mfc, mem_rdata,
        output busy, done, err, rdata, mem_en, mem_rw, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output start, rw, size, sign_ext, addr, wdata, mem_mfc, mem_rdata,
        input  busy, done, err, rdata, mem_en, mem_rw, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller: alignment check, MFC handshake with
// timeout, and sign/zero extension of load data.
module mem_access_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input logic              Clk,
    input logic              Clr,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              rw_q, sx_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [7:0]        cnt_q;

    logic accept, chk_err, mfc_hit, timeout;
    logic busy, done, err, mem_en;

    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] sz, input logic sx);
        logic [DATA_W-1:0] r;
        case (sz)
            2'b00:   r = {{(DATA_W-8){sx & d[7]}}, d[7:0]};
            2'b01:   r = {{(DATA_W-16){sx & d[15]}}, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign accept  = (state_q == IDLE) && bus.start;
    assign chk_err = (size_q == 2'b11)
                  || (size_q == 2'b01 && addr_q[0])
                  || (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign mfc_hit = (state_q == WAIT) && bus.mem_mfc;
    // A response arriving on the last allowed cycle beats the timeout.
    assign timeout = (state_q == WAIT) && !bus.mem_mfc && (cnt_q == 8'(MAX_WAIT - 1));

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CHECK;
            CHECK:   state_d = chk_err ? FINISH : WAIT;
            WAIT:    if (bus.mem_mfc || timeout) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b1;
        done   = 1'b0;
        err    = 1'b0;
        mem_en = 1'b0;
        case (state_q)
            IDLE:    busy = 1'b0;
            WAIT:    mem_en = 1'b1;
            FINISH: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            rw_q    <= 1'b0;
            sx_q    <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (accept) begin
                rw_q    <= bus.rw;
                sx_q    <= bus.sign_ext;
                size_q  <= bus.size;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (state_q == CHECK) begin
                cnt_q <= '0;
                err_q <= chk_err;
            end else if (state_q == WAIT) begin
                if (!bus.mem_mfc) cnt_q <= cnt_q + 8'd1;
                err_q <= timeout;
            end
            if (mfc_hit && rw_q) rdata_q <= extend(bus.mem_rdata, size_q, sx_q);
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err;
    assign bus.mem_en    = mem_en;
    assign bus.rdata     = rdata_q;
    assign bus.mem_rw    = rw_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scenario bench for mem_access_ctrl: directed cases plus randomized accesses
// compared against a transaction-level model of latency, strobe count, err and rdata.
module tb_mem_access_ctrl;
    localparam int MAXW = 4;

    logic Clk = 1'b0;
    logic Clr = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] model_rdata = '0;

    mem_access_ctrl_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAXW)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus.slave)
    );

    always #5 Clk = ~Clk;

    // Expected outcome of one access, derived directly from the access rules.
    function automatic void model(input logic rw, input logic [1:0] size, input logic sx,
                                  input logic [31:0] addr, input int mfc_wait,
                                  input logic [31:0] mrd, output int lat, output int en,
                                  output logic err, inout logic [31:0] rd);
        longint v;
        bit bad;
        bad = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        if (bad) begin
            lat = 2; en = 0; err = 1'b1;
        end else if (mfc_wait < MAXW) begin
            lat = 3 + mfc_wait; en = mfc_wait + 1; err = 1'b0;
            if (rw) begin
                if (size == 2'd0) begin
                    v = mrd % 256;
                    if (sx && v >= 128) v = v - 256;
                end else if (size == 2'd1) begin
                    v = mrd % 65536;
                    if (sx && v >= 32768) v = v - 65536;
                end else begin
                    v = mrd;
                end
                rd = 32'(v);
            end
        end else begin
            lat = 2 + MAXW; en = MAXW; err = 1'b1;
        end
    endfunction

    // Issues one request and plays the memory. Request inputs are scrambled while busy,
    // and mem_mfc is toggled randomly outside WAIT, so both must be ignored.
    task automatic run_access(input logic rw, input logic [1:0] size, input logic sx,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int mfc_wait, input logic [31:0] mrd,
                              output int lat, output int en_cnt, output logic err_seen,
                              output logic done_seen, output int glitches);
        int waits = 0;
        @(negedge Clk);
        bus.start = 1'b1; bus.rw = rw; bus.size = size; bus.sign_ext = sx;
        bus.addr = addr; bus.wdata = wd;
        @(negedge Clk);
        lat = 1; en_cnt = 0; err_seen = 1'b0; done_seen = 1'b0; glitches = 0;
        while (!done_seen && lat < 64) begin
            bus.start = 1'($urandom); bus.rw = 1'($urandom); bus.size = 2'($urandom);
            bus.sign_ext = 1'($urandom); bus.addr = $urandom; bus.wdata = $urandom;
            if (bus.done) begin
                done_seen = 1'b1;
                err_seen  = bus.err;
                if (bus.mem_en) glitches++;
                bus.start = 1'b0;
                bus.mem_mfc = 1'b0;
            end else begin
                if (bus.mem_en) begin
                    en_cnt++;
                    if (bus.mem_addr !== addr || bus.mem_wdata !== wd ||
                        bus.mem_rw !== rw || bus.mem_size !== size) glitches++;
                    bus.mem_mfc   = (waits == mfc_wait);
                    bus.mem_rdata = bus.mem_mfc ? mrd : $urandom;
                    waits++;
                end else begin
                    bus.mem_mfc   = 1'($urandom);
                    bus.mem_rdata = $urandom;
                end
                if (!bus.busy) glitches++;
                @(negedge Clk);
                lat++;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.rw = 1'b1; bus.size = 2'd2; bus.sign_ext = 1'b1;
        bus.addr = 32'h100; bus.wdata = 32'h1234; bus.mem_mfc = 1'b1; bus.mem_rdata = '1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if ({bus.busy, bus.done, bus.err, bus.mem_en, bus.mem_rw, bus.mem_size} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {bus.busy, bus.done, bus.err, bus.mem_en, bus.mem_rw, bus.mem_size});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.rdata} !== 96'd0) begin
            n_bad++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h want all 0",
                     bus.mem_addr, bus.mem_wdata, bus.rdata);
        end
        bus.start = 1'b0; bus.mem_mfc = 1'b0;
        Clr = 1'b1;
    endtask

    task automatic test_word_read();
        int lat, en, g; logic e, d;
        run_access(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 2, 32'hDEADBEEF, lat, en, e, d, g);
        n_cmp++;
        if (!d || lat != 5 || e !== 1'b0 || en != 3 || g != 0) begin
            n_bad++;
            $display("FAIL word_read: done=%b lat=%0d err=%b en=%0d glitch=%0d want 1/5/0/3/0",
                     d, lat, e, en, g);
        end
        model_rdata = 32'hDEADBEEF;
        n_cmp++;
        if (bus.rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL word_rdata: got %h want deadbeef", bus.rdata);
        end
    endtask

    task automatic test_byte_sign();
        int lat, en, g; logic e, d;
        logic [31:0] want [2];
        want[0] = 32'hFFFFFF80;
        want[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            run_access(1'b1, 2'd0, (i == 0), 32'h203, 32'h0, 0, 32'h00000080, lat, en, e, d, g);
            model_rdata = want[i];
            n_cmp++;
            if (!d || lat != 3 || e !== 1'b0 || bus.rdata !== want[i]) begin
                n_bad++;
                $display("FAIL byte_sx%0d: done=%b lat=%0d err=%b rdata=%h want 1/3/0/%h",
                         1 - i, d, lat, e, bus.rdata, want[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int lat, en, g; logic e, d;
        run_access(1'b1, 2'd1, 1'b0, 32'h101, 32'h0, 0, 32'h5555AAAA, lat, en, e, d, g);
        n_cmp++;
        if (!d || lat != 2 || e !== 1'b1 || en != 0 || bus.rdata !== model_rdata) begin
            n_bad++;
            $display("FAIL misaligned: done=%b lat=%0d err=%b en=%0d rdata=%h want 1/2/1/0/%h",
                     d, lat, e, en, bus.rdata, model_rdata);
        end
    endtask

    task automatic test_timeout();
        int lat, en, g; logic e, d;
        run_access(1'b0, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, 1000, 32'h0, lat, en, e, d, g);
        n_cmp++;
        if (!d || lat != 2 + MAXW || e !== 1'b1 || en != MAXW || g != 0 ||
            bus.rdata !== model_rdata) begin
            n_bad++;
            $display("FAIL timeout: done=%b lat=%0d err=%b en=%0d glitch=%0d want 1/%0d/1/%0d/0",
                     d, lat, e, en, g, 2 + MAXW, MAXW);
        end
    endtask

    task automatic test_mfc_at_timeout();
        int lat, en, g; logic e, d;
        run_access(1'b1, 2'd2, 1'b1, 32'h40, 32'h0, MAXW - 1, 32'h8765_4321, lat, en, e, d, g);
        model_rdata = 32'h8765_4321;
        n_cmp++;
        if (!d || lat != 2 + MAXW || e !== 1'b0 || en != MAXW || bus.rdata !== model_rdata) begin
            n_bad++;
            $display("FAIL mfc_at_timeout: done=%b lat=%0d err=%b en=%0d rdata=%h want 1/%0d/0/%0d/%h",
                     d, lat, e, en, bus.rdata, 2 + MAXW, MAXW, model_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        int lat, en, g, k; logic e, d;
        logic saw_done = 1'b0;
        @(negedge Clk);
        bus.start = 1'b1; bus.rw = 1'b1; bus.size = 2'd2; bus.addr = 32'h300; bus.mem_mfc = 1'b0;
        @(negedge Clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.mem_en && k < 5) begin
            @(negedge Clk);
            k++;
        end
        n_cmp++;
        if (!bus.mem_en) begin
            n_bad++;
            $display("FAIL rst_wait_enter: mem_en=%b want 1", bus.mem_en);
        end
        @(posedge Clk);
        #2 Clr = 1'b0;
        #1;
        model_rdata = '0;
        n_cmp++;
        if (bus.mem_en !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_wait_async: mem_en=%b busy=%b rdata=%h want 0/0/0",
                     bus.mem_en, bus.busy, bus.rdata);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            if (bus.done) saw_done = 1'b1;
        end
        Clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            if (bus.done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL rst_wait_nodone: done pulse seen=1 want 0");
        end
        run_access(1'b1, 2'd1, 1'b0, 32'h302, 32'h0, 1, 32'h0001_F00D, lat, en, e, d, g);
        model_rdata = 32'h0000_F00D;
        n_cmp++;
        if (!d || lat != 4 || e !== 1'b0 || bus.rdata !== model_rdata) begin
            n_bad++;
            $display("FAIL rst_wait_after: done=%b lat=%0d err=%b rdata=%h want 1/4/0/%h",
                     d, lat, e, bus.rdata, model_rdata);
        end
    endtask

    task automatic test_random(input int n);
        int lat, en, g, x_lat, x_en, mw;
        logic e, d, x_err, rw, sx;
        logic [1:0] size;
        logic [31:0] addr, wd, mrd;
        for (int i = 0; i < n; i++) begin
            rw = 1'($urandom); sx = 1'($urandom); size = 2'($urandom_range(0, 3));
            addr = $urandom; wd = $urandom; mrd = $urandom;
            if ($urandom_range(0, 1) == 0) addr = addr & 32'hFFFF_FFFC;
            mw = $urandom_range(0, MAXW + 1);
            model(rw, size, sx, addr, mw, mrd, x_lat, x_en, x_err, model_rdata);
            run_access(rw, size, sx, addr, wd, mw, mrd, lat, en, e, d, g);
            n_cmp++;
            if (!d || lat != x_lat || e !== x_err || en != x_en || g != 0 ||
                bus.rdata !== model_rdata) begin
                n_bad++;
                $display("FAIL random%0d: done=%b lat=%0d err=%b en=%0d glitch=%0d rdata=%h want 1/%0d/%b/%0d/0/%h",
                         i, d, lat, e, en, g, bus.rdata, x_lat, x_err, x_en, model_rdata);
            end
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.rw = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
        bus.addr = '0; bus.wdata = '0; bus.mem_mfc = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_word_read();
        test_byte_sign();
        test_misaligned();
        test_timeout();
        test_mfc_at_timeout();
        test_reset_in_wait();
        test_random(80);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data path width (multiple of 16, at least 32).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter MAX_WAIT, default 15, maximum cycles spent waiting for MFC before timeout (1..255).
REQ-004 Clk  input  1  sole clock, rising edge.
REQ-005 Clr  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request pulse, sampled only in IDLE.
REQ-007 rw  input  1  1 = read (load), 0 = write (store).
REQ-008 size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 sign_ext  input  1  for reads: 1 = sign-extend, 0 = zero-extend.
REQ-010 addr  input  ADDR_W  byte address.
REQ-011 wdata  input  DATA_W  store data, right-justified.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  valid with done: 1 = misaligned, illegal size, or timeout.
REQ-015 rdata  output  DATA_W  extended load result, held until the next completed read.
REQ-016 mem_en  output  1  memory request strobe.
REQ-017 mem_rw  output  1  copy of the latched rw.
REQ-018 mem_size  output  2  copy of the latched size.
REQ-019 mem_addr  output  ADDR_W  latched address.
REQ-020 mem_wdata  output  DATA_W  latched store data.
REQ-021 mem_mfc  input  1  memory function complete.
REQ-022 mem_rdata  input  DATA_W  read data, right-justified, valid with mem_mfc.

Function
REQ-023 States SHALL be IDLE, CHECK, WAIT, FINISH.
REQ-024 In IDLE with start=1, the block SHALL latch rw, size, sign_ext, addr and wdata, then go to CHECK; start outside IDLE SHALL be ignored.
REQ-025 CHECK SHALL flag an error if size=11, if size=01 and addr[0]=1, or if size=10 and addr[1:0]!=00.
REQ-026 On an error in CHECK, the block SHALL go to FINISH with err pending and SHALL NOT assert mem_en.
REQ-027 Otherwise CHECK SHALL assert mem_en, clear the wait counter, and go to WAIT.
REQ-028 In WAIT, mem_en SHALL stay high and mem_addr/mem_wdata/mem_rw/mem_size SHALL stay stable until mem_mfc=1 is sampled.
REQ-029 mem_mfc=1 in WAIT SHALL drop mem_en on the next edge and go to FINISH; for reads, that same edge SHALL capture the extended mem_rdata into rdata.
REQ-030 Read extension: byte uses mem_rdata[7:0]; halfword uses mem_rdata[15:0]; word uses the full width; upper bits are filled with the sign bit when sign_ext=1, else zero.
REQ-031 The wait counter SHALL increment each WAIT cycle without mem_mfc.
REQ-032 When the counter reaches MAX_WAIT without mem_mfc, the block SHALL drop mem_en, go to FINISH with err pending, and leave rdata unchanged.
REQ-033 mem_mfc in the same cycle as the timeout SHALL win: the access completes normally.
REQ-034 FINISH SHALL assert done=1 for exactly one cycle with err=pending flag, then return to IDLE.
REQ-035 Minimum latency from start to done: 3 cycles when mem_mfc arrives on the first WAIT cycle; 2 cycles for a CHECK error.
REQ-036 mem_mfc outside WAIT SHALL be ignored.
REQ-037 done and mem_en SHALL never be high together.

Reset
REQ-038 Clr=0 SHALL asynchronously force IDLE and clear busy, done, err, mem_en, mem_rw, mem_size, mem_addr, mem_wdata, rdata and the wait counter.
REQ-039 Reset during WAIT SHALL abort the access with no done pulse.
REQ-040 After Clr returns to 1, the first start SHALL be accepted on the following edge.

Verification
REQ-041 Word read: addr=0x100, size=10, mem_mfc after 2 WAIT cycles, mem_rdata=0xDEADBEEF -> done at cycle 5, err=0, rdata=0xDEADBEEF.
REQ-042 Byte read with sign_ext=1, mem_rdata=0x00000080 -> rdata=0xFFFFFF80; the same read with sign_ext=0 -> rdata=0x00000080.
REQ-043 Misaligned halfword read at addr=0x101 -> mem_en never high, done with err=1 two cycles after start, rdata unchanged.
REQ-044 Write, MAX_WAIT=4, mem_mfc never asserted -> mem_en high for 4 cycles, then done with err=1.
REQ-045 mem_mfc asserted in the same cycle the counter reaches MAX_WAIT -> done with err=0.
REQ-046 Clr pulsed low in WAIT -> mem_en and busy go low immediately and no done pulse occurs; a new start then completes normally.
